// File: rtl/rr_mux_8x1.sv
// Registered 8-to-1 round-robin merge: picks one valid channel per cycle,
// tags the beat with its source index and holds it in a single output stage.

module rr_mux_8x1_lane #(
  parameter int DATA_W = 8
) (
  input  logic              i_sel,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);
  assign o_data = i_sel ? i_data : '0;
endmodule

module rr_mux_8x1 #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_valid,
  input  logic [8*DATA_W-1:0]   in_data,
  output logic [7:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            out_sel,
  input  logic                  out_ready
);
  localparam int NUM_LANES = 8;

  logic [2:0]                         r_ptr;
  logic                               r_out_valid;
  logic [DATA_W-1:0]                  r_out_data;
  logic [2:0]                         r_out_sel;

  logic                               w_load_en;
  logic                               w_gnt_vld;
  logic [2:0]                         w_gnt_idx;
  logic [NUM_LANES-1:0]               w_grant;
  logic                               w_xfer;
  logic [NUM_LANES-1:0][DATA_W-1:0]   w_lane_q;
  logic [DATA_W-1:0]                  w_mux_data;

  assign w_load_en = ~r_out_valid | out_ready;

  // First valid channel at or after r_ptr, wrapping through 3-bit addition.
  always_comb begin
    logic [2:0] idx;
    idx       = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = r_ptr + 3'(k);
      if (!w_gnt_vld && in_valid[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  // rst_n gate keeps in_ready quiet while reset is held.
  assign w_grant  = (w_gnt_vld && w_load_en && rst_n) ? (NUM_LANES'(1) << w_gnt_idx) : '0;
  assign in_ready = w_grant;
  assign w_xfer   = |w_grant;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rr_mux_8x1_lane #(.DATA_W(DATA_W)) u_lane (
      .i_sel  (w_grant[g]),
      .i_data (in_data[g*DATA_W +: DATA_W]),
      .o_data (w_lane_q[g])
    );
  end

  always_comb begin
    w_mux_data = '0;
    for (int k = 0; k < NUM_LANES; k++) w_mux_data = w_mux_data | w_lane_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_mux_data;
        r_out_sel  <= w_gnt_idx;
        r_ptr      <= w_gnt_idx + 3'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
endmodule

// File: tb/tb_rr_mux_8x1.sv
// Directed + random checks of rr_mux_8x1 against an integer round-robin model.

module tb_rr_mux_8x1;
  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        in_valid;
  logic [8*W-1:0]    in_data;
  logic [7:0]        in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [2:0]        out_sel;
  logic              out_ready;

  int tests = 0;
  int fails = 0;

  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_sel;
  int         m_ptr;

  always #5 clk = ~clk;

  rr_mux_8x1 #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < 8; k++)
      if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
    chk({tag, ".out_sel"},   32'(out_sel),   32'(m_sel));
  endtask

  // Inputs already driven; check in_ready, advance one edge, check outputs.
  task automatic tick(input string tag);
    int g;
    #1;
    g = model_grant();
    chk({tag, ".in_ready"}, 32'(in_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
        m_ptr   = (g + 1) % 8;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_out(tag);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out("async_rst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #1 check_out("rst0");
    repeat (3) begin
      in_valid = 8'($urandom); in_data = {$urandom, $urandom}; out_ready = 1'($urandom);
      tick("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // single channel 3
    in_data = {$urandom, $urandom};
    in_data[3*W +: W] = 8'hA5;
    in_valid = 8'h08; out_ready = 1'b1;
    tick("single");
    chk("single.sel_3", 32'(out_sel), 32'd3);
    chk("single.data_a5", 32'(out_data), 32'hA5);
    in_valid = '0;
    tick("single_drain");

    // all valid: 0..7,0,1 back to back
    async_reset();
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = 8'(8'h10 + i);
    in_valid = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick("rr");
      chk("rr.order", 32'(out_sel), 32'(k % 8));
      chk("rr.nobubble", 32'(out_valid), 32'd1);
    end

    // backpressure with channels 0 and 7
    async_reset();
    in_valid = 8'h81; out_ready = 1'b0;
    tick("bp_load");
    repeat (4) begin
      tick("bp_hold");
      chk("bp.sel_stable", 32'(out_sel), 32'd0);
    end
    out_ready = 1'b1;
    tick("bp_rel7");
    chk("bp.next7", 32'(out_sel), 32'd7);
    tick("bp_rel0");
    chk("bp.next0", 32'(out_sel), 32'd0);

    // drain with nothing valid
    in_valid = '0;
    tick("idle");
    chk("idle.valid_low", 32'(out_valid), 32'd0);
    chk("idle.sel_hold", 32'(out_sel), 32'd0);

    // reset mid-stream
    in_valid = 8'hFF;
    tick("pre_rst");
    chk("pre_rst.valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1 check_out("mid_rst");
    tick("in_rst");
    rst_n = 1'b1;
    tick("post_rst");
    chk("post_rst.sel0", 32'(out_sel), 32'd0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      in_valid  = 8'($urandom) & 8'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
